// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring unsigned divider, one quotient bit per clock
module divider #(
    parameter int BITS = 4
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [BITS-1:0] i_dividend,
    input  logic [BITS-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_finished,
    output logic [BITS-1:0] o_quotient,
    output logic [BITS-1:0] o_remainder,
    output logic            o_divide_by_zero
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(BITS);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BITS-1:0] d_reg;
    logic [BITS-1:0] q_reg;
    // Partial remainder between steps is always below D, so its top bit is
    // only needed transiently inside the shift/compare.
    logic [BITS-1:0] r_reg;
    logic [CW-1:0]   count;
    logic            dz_reg;

    logic            accept;
    logic [BITS:0]   r_shift;
    logic            fits;
    logic [BITS-1:0] r_step;
    logic [BITS-1:0] q_step;

    always_comb begin
        accept  = (state == IDLE) && i_start;
        r_shift = {r_reg, q_reg[BITS-1]};
        fits    = r_shift >= {1'b0, d_reg};
        r_step  = fits ? BITS'(r_shift - {1'b0, d_reg}) : r_shift[BITS-1:0];
        q_step  = {q_reg[BITS-2:0], fits};
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                if (count == COUNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A zero divisor spends a single idle step in DIVIDE so its result is
    // presented one cycle after acceptance, with the saturated quotient.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            d_reg  <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            count  <= '0;
            dz_reg <= 1'b0;
        end else if (accept) begin
            d_reg  <= i_divisor;
            dz_reg <= 1'b0;
            if (i_divisor == '0) begin
                q_reg <= '1;
                r_reg <= i_dividend;
                count <= COUNT_LAST;
            end else begin
                q_reg <= i_dividend;
                r_reg <= '0;
                count <= COUNT_INIT;
            end
        end else if (state == DIVIDE) begin
            count <= count - COUNT_LAST;
            if (d_reg == '0) begin
                dz_reg <= 1'b1;
            end else begin
                r_reg <= r_step;
                q_reg <= q_step;
            end
        end
    end

    assign o_busy           = (state != IDLE);
    assign o_finished       = (state == DONE);
    assign o_quotient       = q_reg;
    assign o_remainder      = r_reg;
    assign o_divide_by_zero = dz_reg;

endmodule
